// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operand width and opcode encoding.
package alu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        ALU_OP_MOV  = 3'd0,
        ALU_OP_NOT  = 3'd1,
        ALU_OP_AND  = 3'd2,
        ALU_OP_ADD  = 3'd3,
        ALU_OP_NOR  = 3'd4,
        ALU_OP_NAND = 3'd5,
        ALU_OP_SUB  = 3'd6,
        ALU_OP_SLT  = 3'd7
    } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational 33-bit adder/subtractor shared by ADD, SUB and SLT.
module alu_addsub
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sub,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_carry,
    output logic              o_ovf
);

    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_full;

    always_comb begin
        w_b    = i_sub ? ~i_b : i_b;
        w_full = {1'b0, i_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, i_sub};
        o_sum  = w_full[DATA_W-1:0];
        // Subtraction carries out when no borrow occurred, so the borrow is its inverse.
        o_carry = i_sub ? ~w_full[DATA_W] : w_full[DATA_W];
        // Comparing A with the (possibly inverted) B covers both the ADD and SUB overflow rules.
        o_ovf   = (i_a[DATA_W-1] == w_b[DATA_W-1]) && (o_sum[DATA_W-1] != i_a[DATA_W-1]);
    end

endmodule

// File: rtl/alu.sv
// Single-cycle 32-bit ALU with registered result and status flags (EX/MEM boundary).
module alu
    import alu_pkg::*;
(
    input  logic              ALU_CLK,
    input  logic              ALU_RESETN,
    input  logic [DATA_W-1:0] ALU_R2,
    input  logic [DATA_W-1:0] ALU_R3,
    input  logic [2:0]        ALU_ALUOP,
    output logic [DATA_W-1:0] ALU_R1,
    output logic              ALU_ZERO,
    output logic              ALU_CARRY,
    output logic              ALU_OVF
);

    alu_op_e           w_op;
    logic              w_sub;
    logic [DATA_W-1:0] w_sum;
    logic              w_as_carry;
    logic              w_as_ovf;
    logic [DATA_W-1:0] w_result;
    logic              w_carry;
    logic              w_ovf;

    logic [DATA_W-1:0] r_r1;
    logic              r_zero;
    logic              r_carry;
    logic              r_ovf;

    assign w_op  = alu_op_e'(ALU_ALUOP);
    assign w_sub = (w_op == ALU_OP_SUB) || (w_op == ALU_OP_SLT);

    alu_addsub u_addsub (
        .i_a     (ALU_R2),
        .i_b     (ALU_R3),
        .i_sub   (w_sub),
        .o_sum   (w_sum),
        .o_carry (w_as_carry),
        .o_ovf   (w_as_ovf)
    );

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (w_op)
            ALU_OP_MOV:  w_result = ALU_R2;
            ALU_OP_NOT:  w_result = ~ALU_R2;
            ALU_OP_AND:  w_result = ALU_R2 & ALU_R3;
            ALU_OP_ADD: begin
                w_result = w_sum;
                w_carry  = w_as_carry;
                w_ovf    = w_as_ovf;
            end
            ALU_OP_NOR:  w_result = ~(ALU_R2 | ALU_R3);
            ALU_OP_NAND: w_result = ~(ALU_R2 & ALU_R3);
            ALU_OP_SUB: begin
                w_result = w_sum;
                w_carry  = w_as_carry;
                w_ovf    = w_as_ovf;
            end
            // Sign of the difference corrected by overflow gives the true signed ordering.
            ALU_OP_SLT:  w_result = {{(DATA_W-1){1'b0}}, w_sum[DATA_W-1] ^ w_as_ovf};
            default:     w_result = '0;
        endcase
    end

    always_ff @(posedge ALU_CLK) begin
        if (!ALU_RESETN) begin
            r_r1    <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_r1    <= w_result;
            r_zero  <= (w_result == '0);
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
        end
    end

    assign ALU_R1    = r_r1;
    assign ALU_ZERO  = r_zero;
    assign ALU_CARRY = r_carry;
    assign ALU_OVF   = r_ovf;

endmodule

// File: tb/tb_alu.sv
// Directed table-driven bench for the registered ALU.
module tb_alu;
    import alu_pkg::*;

    logic        ALU_CLK;
    logic        ALU_RESETN;
    logic [31:0] ALU_R2;
    logic [31:0] ALU_R3;
    logic [2:0]  ALU_ALUOP;
    logic [31:0] ALU_R1;
    logic        ALU_ZERO;
    logic        ALU_CARRY;
    logic        ALU_OVF;

    int unsigned n_cmp;
    int unsigned n_bad;

    typedef struct {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        o;
    } vec_t;

    vec_t vecs[$];

    alu dut (
        .ALU_CLK    (ALU_CLK),
        .ALU_RESETN (ALU_RESETN),
        .ALU_R2     (ALU_R2),
        .ALU_R3     (ALU_R3),
        .ALU_ALUOP  (ALU_ALUOP),
        .ALU_R1     (ALU_R1),
        .ALU_ZERO   (ALU_ZERO),
        .ALU_CARRY  (ALU_CARRY),
        .ALU_OVF    (ALU_OVF)
    );

    initial ALU_CLK = 1'b0;
    always #5 ALU_CLK = ~ALU_CLK;

    task automatic check(input string name, input logic [31:0] er, input logic ez,
                         input logic ec, input logic eo);
        n_cmp++;
        if (ALU_R1 !== er || ALU_ZERO !== ez || ALU_CARRY !== ec || ALU_OVF !== eo) begin
            n_bad++;
            $display("FAIL %s: got R1=%h Z=%b C=%b O=%b, want R1=%h Z=%b C=%b O=%b",
                     name, ALU_R1, ALU_ZERO, ALU_CARRY, ALU_OVF, er, ez, ec, eo);
        end
    endtask

    task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        ALU_ALUOP = op;
        ALU_R2    = a;
        ALU_R3    = b;
    endtask

    function automatic void add(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic c, input logic o);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.r = r;
        v.z  = (r == 32'd0);
        v.c  = c; v.o = o;
        vecs.push_back(v);
    endfunction

    initial begin
        string nm;
        n_cmp = 0;
        n_bad = 0;

        // op, A, B, result, carry, ovf (zero derived from result)
        add(ALU_OP_ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0);
        add(ALU_OP_ADD,  32'd1000,     32'd999,      32'd1999,     1'b0, 1'b0);
        add(ALU_OP_ADD,  32'd54,       -32'sd53,     32'd1,        1'b1, 1'b0);
        add(ALU_OP_ADD,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1);
        add(ALU_OP_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1);
        add(ALU_OP_SUB,  32'd323,      32'd323,      32'd0,        1'b0, 1'b0);
        add(ALU_OP_SUB,  32'd23,       32'd67,       32'hFFFFFFD4, 1'b1, 1'b0);
        add(ALU_OP_SUB,  32'd100,      -32'sd25,     32'd125,      1'b1, 1'b0);
        add(ALU_OP_SUB,  -32'sd32,     -32'sd32,     32'd0,        1'b0, 1'b0);
        add(ALU_OP_SUB,  32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1);
        add(ALU_OP_SUB,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1);
        add(ALU_OP_SLT,  32'd65,       32'd3,        32'd0,        1'b0, 1'b0);
        add(ALU_OP_SLT,  32'd25,       -32'sd23,     32'd0,        1'b0, 1'b0);
        add(ALU_OP_SLT,  32'd4,        32'd6,        32'd1,        1'b0, 1'b0);
        add(ALU_OP_SLT,  -32'sd54,     32'd4,        32'd1,        1'b0, 1'b0);
        add(ALU_OP_SLT,  32'd4,        32'd4,        32'd0,        1'b0, 1'b0);
        add(ALU_OP_SLT,  32'd0,        -32'sd60,     32'd0,        1'b0, 1'b0);
        add(ALU_OP_SLT,  -32'sd90,     32'd0,        32'd1,        1'b0, 1'b0);
        add(ALU_OP_SLT,  32'h80000000, 32'd1,        32'd1,        1'b0, 1'b0);
        add(ALU_OP_SLT,  32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0, 1'b0);
        add(ALU_OP_SLT,  32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b0);
        add(ALU_OP_AND,  32'h008CF797, 32'h000392FA, 32'h00009292, 1'b0, 1'b0);
        add(ALU_OP_NOR,  32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0);
        add(ALU_OP_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0);
        add(ALU_OP_NAND, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        add(ALU_OP_MOV,  32'd65,       32'd7,        32'd65,       1'b0, 1'b0);
        add(ALU_OP_NOT,  32'd23,       32'hABCDEF01, 32'hFFFFFFE8, 1'b0, 1'b0);
        add(ALU_OP_MOV,  32'd0,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0);

        // Reset held: ADD 5+12 must not reach the outputs.
        ALU_RESETN = 1'b0;
        drive(ALU_OP_ADD, 32'd5, 32'd12);
        @(posedge ALU_CLK); @(posedge ALU_CLK);
        #1 check("reset_hold", 32'd0, 1'b0, 1'b0, 1'b0);

        @(negedge ALU_CLK);
        ALU_RESETN = 1'b1;
        @(posedge ALU_CLK);
        #1 check("reset_release", 32'd17, 1'b0, 1'b0, 1'b0);

        // Back-to-back: new opcode every edge, output lags by exactly one edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge ALU_CLK);
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            if (i > 0) begin
                nm = $sformatf("hold_before_edge_%0d", i);
                check(nm, vecs[i-1].r, vecs[i-1].z, vecs[i-1].c, vecs[i-1].o);
            end
            @(posedge ALU_CLK);
            #1;
            nm = $sformatf("vec_%0d_op%0d", i, vecs[i].op);
            check(nm, vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].o);
        end

        // Inputs changing between edges must not disturb the registered outputs.
        @(negedge ALU_CLK);
        drive(ALU_OP_ADD, 32'd1000, 32'd999);
        @(posedge ALU_CLK);
        #2 drive(ALU_OP_NOT, 32'd0, 32'd0);
        @(negedge ALU_CLK);
        check("mid_cycle_input_change", 32'd1999, 1'b0, 1'b0, 1'b0);
        @(posedge ALU_CLK);
        #1 check("after_change_edge", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

        // Reset overrides a computation that would set carry, ovf and zero.
        @(negedge ALU_CLK);
        drive(ALU_OP_ADD, 32'h80000000, 32'h80000000);
        ALU_RESETN = 1'b0;
        @(posedge ALU_CLK);
        #1 check("reset_overrides", 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge ALU_CLK);
        ALU_RESETN = 1'b1;
        @(posedge ALU_CLK);
        #1 check("post_reset_flags", 32'd0, 1'b1, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
